// File: rtl/run_controller.sv
// -----------------------------------------------------------------------------
// run_controller
//
// Sequences instruction execution for a simple processor core. The block walks
// IDLE -> FETCH -> EXEC and then either loops back to FETCH, parks in PAUSE
// (single-step mode), or stops in HALT (HLT instruction or fetch timeout).
//
// Ports
//   clk        in   1   rising-edge clock for all state
//   rst        in   1   asynchronous active-high reset
//   start      in   1   begin/resume; only looked at in IDLE and HALT
//   step_mode  in   1   1 = pause after every executed instruction
//   step_req   in   1   level request to leave PAUSE
//   flag_HLT   in   1   decoder halt flag, active-low (0 = HLT in EXEC)
//   imem_ack   in   1   instruction memory data valid (used only in FETCH)
//   imem_req   out  1   instruction fetch request, high for every FETCH cycle
//   ir_load    out  1   strobe to latch the fetched instruction (FETCH & ack)
//   commit_en  out  1   gates PC / register-file / data-memory writes
//   halted     out  1   high while in HALT
//   fetch_err  out  1   sticky fetch-timeout flag, cleared by start in HALT
//   state      out  3   current state code (IDLE=0 .. HALT=4)
//   retired    out  16  committed instruction count, wraps at 0xFFFF
// -----------------------------------------------------------------------------
module run_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step_mode,
  input  logic        step_req,
  input  logic        flag_HLT,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic        ir_load,
  output logic        commit_en,
  output logic        halted,
  output logic        fetch_err,
  output logic [2:0]  state,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_PAUSE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  // The wait counter holds the number of ack-less FETCH cycles already spent.
  // The cycle that would push it to 255 is the last one allowed: with no ack
  // there, the fetch is abandoned. An ack in that same cycle still wins.
  localparam logic [7:0] WAIT_LAST = 8'd254;

  state_t      cur;
  logic [7:0]  wait_cnt;
  logic        fetch_err_q;
  logic [15:0] retired_q;

  // HLT is active-low: an instruction commits only when flag_HLT is high.
  logic exec_commit;
  assign exec_commit = (cur == S_EXEC) && flag_HLT;

  // ---------------------------------------------------------------------------
  // State machine and counters.
  // Every path into FETCH clears the wait counter so each fetch gets a full
  // timeout window regardless of where it came from.
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every branch below
  // reads the pre-edge values of cur/wait_cnt/retired_q, independent of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur         <= S_IDLE;
      wait_cnt    <= 8'd0;
      fetch_err_q <= 1'b0;
      retired_q   <= 16'd0;
    end else begin
      case (cur)
        S_IDLE: begin
          if (start) begin
            cur      <= S_FETCH;
            wait_cnt <= 8'd0;
          end
        end

        S_FETCH: begin
          if (imem_ack) begin
            cur <= S_EXEC;
          end else if (wait_cnt == WAIT_LAST) begin
            cur         <= S_HALT;
            wait_cnt    <= wait_cnt + 8'd1;
            fetch_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        S_EXEC: begin
          if (!flag_HLT) begin
            // HLT: nothing commits, the count is left as it is.
            cur <= S_HALT;
          end else begin
            retired_q <= retired_q + 16'd1;
            if (step_mode) begin
              cur <= S_PAUSE;
            end else begin
              cur      <= S_FETCH;
              wait_cnt <= 8'd0;
            end
          end
        end

        S_PAUSE: begin
          // PAUSE is only entered with step_mode high, so seeing it low here
          // means the user dropped out of single-step mode.
          if (step_req || !step_mode) begin
            cur      <= S_FETCH;
            wait_cnt <= 8'd0;
          end
        end

        S_HALT: begin
          if (start) begin
            cur         <= S_FETCH;
            wait_cnt    <= 8'd0;
            fetch_err_q <= 1'b0;
          end
        end

        // Unused codes 5-7 recover to IDLE on the next edge.
        default: begin
          cur <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state. Only ir_load and commit_en look at
  // inputs, so the instruction latch and write enables act in the same cycle
  // as the ack / decode they depend on.
  // ---------------------------------------------------------------------------
  assign imem_req  = (cur == S_FETCH);
  assign ir_load   = (cur == S_FETCH) && imem_ack;
  assign commit_en = exec_commit;
  assign halted    = (cur == S_HALT);
  assign fetch_err = fetch_err_q;
  assign state     = cur;
  assign retired   = retired_q;

endmodule
